// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter family (tx now, rx later).
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_mode_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int unsigned MAX_DATA_BITS = 9;

  // Data is zero-extended to the widest legal frame; zeros do not change the XOR.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy counter; push while full and pop while empty are ignored.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   LVL_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   LVL_ZERO = (PTR_W+1)'(0);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_level == LVL_FULL);
  assign o_empty = (r_level == LVL_ZERO);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rd_ptr];

  // Storage array, data path only.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= LVL_ZERO;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// Buffered UART transmitter with configurable width/stop bits and runtime parity.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_fifo_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CYCLES_PER_BIT = 434,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned STOP_BITS      = 1,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tvalid,
  output logic                          tready,
  input  logic [DATA_BITS-1:0]          tdata,
  input  logic [1:0]                    parity_mode,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned BAUD_W = $clog2(CYCLES_PER_BIT);
  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BIT_W  = 4;

  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CYCLES_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ZERO   = BAUD_W'(0);
  localparam logic [BAUD_W-1:0] BAUD_ONE    = BAUD_W'(1);
  localparam logic [BIT_W-1:0]  LAST_DATA   = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  LAST_STOP   = BIT_W'(STOP_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ZERO    = BIT_W'(0);
  localparam logic [BIT_W-1:0]  BIT_ONE     = BIT_W'(1);
  localparam logic [LVL_W-1:0]  LVL_FULL    = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]  LVL_ZERO    = LVL_W'(0);

  tx_state_t              r_state;
  tx_state_t              w_state_nxt;
  logic [BAUD_W-1:0]      r_baud;
  logic [BAUD_W-1:0]      w_baud_nxt;
  logic [BIT_W-1:0]       r_bit;
  logic [BIT_W-1:0]       w_bit_nxt;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   w_shift_nxt;
  logic                   r_tx;
  logic                   w_tx_nxt;
  logic                   r_tready;
  logic                   r_busy;
  logic                   w_push;
  logic                   w_pop;
  logic [DATA_BITS-1:0]   w_rdata;
  logic                   w_full;
  logic                   w_empty;
  logic [LVL_W-1:0]       w_level;
  logic [LVL_W-1:0]       w_level_nxt;

  assign w_push      = tvalid && r_tready;
  assign w_level_nxt = w_level + LVL_W'(w_push) - LVL_W'(w_pop);

  assign tx         = r_tx;
  assign tready     = r_tready;
  assign busy       = r_busy;
  assign fifo_level = w_level;

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (tdata),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

`ifdef UART_TX_PARITY_EN
  logic r_par_en;
  logic r_par_bit;

  // Parity choice is latched with the word so mid-frame mode changes wait for the next frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else if (w_pop) begin
      r_par_en  <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
      r_par_bit <= parity_bit(MAX_DATA_BITS'(w_rdata), parity_mode == PAR_ODD);
    end
  end
`else
  logic w_unused_mode;
  assign w_unused_mode = ^parity_mode;
`endif

  // Frame sequencer: every state advances only when the baud counter has run out.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    if ((r_state != IDLE) && (r_baud != BAUD_ZERO)) begin
      w_baud_nxt = r_baud - BAUD_ONE;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = START;
            w_tx_nxt    = 1'b0;
            w_baud_nxt  = BAUD_RELOAD;
            w_shift_nxt = w_rdata;
          end else begin
            w_tx_nxt = 1'b1;
          end
        end
        START: begin
          w_state_nxt = DATA;
          w_tx_nxt    = r_shift[0];
          w_baud_nxt  = BAUD_RELOAD;
          w_bit_nxt   = BIT_ZERO;
        end
        DATA: begin
          w_baud_nxt = BAUD_RELOAD;
          if (r_bit == LAST_DATA) begin
            w_bit_nxt = BIT_ZERO;
`ifdef UART_TX_PARITY_EN
            if (r_par_en) begin
              w_state_nxt = PARITY;
              w_tx_nxt    = r_par_bit;
            end else begin
              w_state_nxt = STOP;
              w_tx_nxt    = 1'b1;
            end
`else
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
`endif
          end else begin
            w_shift_nxt = r_shift >> 1;
            w_tx_nxt    = r_shift[1];
            w_bit_nxt   = r_bit + BIT_ONE;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          w_state_nxt = STOP;
          w_tx_nxt    = 1'b1;
          w_baud_nxt  = BAUD_RELOAD;
          w_bit_nxt   = BIT_ZERO;
        end
`endif
        STOP: begin
          w_baud_nxt = BAUD_RELOAD;
          if (r_bit != LAST_STOP) begin
            w_bit_nxt = r_bit + BIT_ONE;
          end else if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = START;
            w_tx_nxt    = 1'b0;
            w_shift_nxt = w_rdata;
          end else begin
            w_state_nxt = IDLE;
            w_tx_nxt    = 1'b1;
            w_baud_nxt  = BAUD_ZERO;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_tx_nxt    = 1'b1;
          w_baud_nxt  = BAUD_ZERO;
        end
      endcase
    end
  end

  // tready and busy are registered from next-state values so they line up with fifo_level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_tx     <= 1'b1;
      r_baud   <= BAUD_ZERO;
      r_bit    <= BIT_ZERO;
      r_shift  <= '0;
      r_tready <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tx     <= w_tx_nxt;
      r_baud   <= w_baud_nxt;
      r_bit    <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_tready <= (w_level_nxt != LVL_FULL);
      r_busy   <= (w_state_nxt != IDLE) || (w_level_nxt != LVL_ZERO);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Self-checking bench: a line decoder reconstructs frames from tx and compares them to a
// queue of accepted words; a second instance exercises 7 data bits with 2 stop bits.
module tb_uart_tx_fifo_cfg;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;
  logic [1:0] parity_mode;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_level;

  logic       tvalid_w;
  logic       tready_w;
  logic [6:0] tdata_w;
  logic       tx_w;
  logic       busy_w;
  logic [2:0] fifo_level_w;

  int     checks = 0;
  int     failures = 0;
  int     frames_done = 0;
  int     frames_started = 0;
  longint cyc = 0;
  longint start_q[$];
  exp_t   exp_q[$];
  logic   mon_abort = 1'b0;

  uart_tx_fifo_cfg #(
    .CYCLES_PER_BIT (CPB), .DATA_BITS (8), .STOP_BITS (1), .FIFO_DEPTH (4)
  ) u_dut (
    .clk (clk), .rst_n (rst_n), .tvalid (tvalid), .tready (tready), .tdata (tdata),
    .parity_mode (parity_mode), .tx (tx), .busy (busy), .fifo_level (fifo_level)
  );

  uart_tx_fifo_cfg #(
    .CYCLES_PER_BIT (CPB), .DATA_BITS (7), .STOP_BITS (2), .FIFO_DEPTH (4)
  ) u_dut_w (
    .clk (clk), .rst_n (rst_n), .tvalid (tvalid_w), .tready (tready_w), .tdata (tdata_w),
    .parity_mode (2'b00), .tx (tx_w), .busy (busy_w), .fifo_level (fifo_level_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_wait(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rst_n !== 1'b1) mon_abort = 1'b1;
    end
  endtask

  // Line decoder: samples every bit at its midpoint after detecting the start edge.
  initial begin : p_monitor
    logic [7:0] d;
    logic       s, pb, sp, have, par_exp;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        mon_abort = 1'b0;
        frames_started++;
        start_q.push_back(cyc);
        mon_wait(CPB / 2);
        s = tx;
        for (int i = 0; i < 8; i++) begin
          mon_wait(CPB);
          d[i] = tx;
        end
        have = (exp_q.size() != 0);
        if (have) e = exp_q[0];
        else e = '{data: 8'h00, mode: 2'b00};
        par_exp = PAR_BUILD && (e.mode == 2'b01 || e.mode == 2'b10);
        pb = 1'b0;
        if (par_exp) begin
          mon_wait(CPB);
          pb = tx;
        end
        mon_wait(CPB);
        sp = tx;
        if (!mon_abort) begin
          check("frame_expected", 32'(have), 32'd1);
          if (have) void'(exp_q.pop_front());
          check("start_bit", 32'(s), 32'd0);
          check("frame_data", 32'(d), 32'(e.data));
          if (par_exp) check("parity_bit", 32'(pb), 32'((e.mode == 2'b10) ? ~^e.data : ^e.data));
          check("stop_bit", 32'(sp), 32'd1);
          frames_done++;
        end
      end
    end
  end

  task automatic push(input logic [7:0] d, input logic [1:0] m);
    int   n;
    exp_t e;
    @(negedge clk);
    tvalid = 1'b1;
    tdata  = d;
    n = 0;
    while (tready !== 1'b1 && n < 20 * CPB) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", 32'(tready), 32'd1);
    @(posedge clk);
    e.data = d;
    e.mode = m;
    exp_q.push_back(e);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frames_reached", 32'(frames_done >= target), 32'd1);
  endtask

  task automatic wait_started(input int target);
    int n = 0;
    while (frames_started < target && n < 40 * CPB) begin
      @(negedge clk);
      n++;
    end
    check("frame_started", 32'(frames_started >= target), 32'd1);
  endtask

  initial begin : p_main
    int   base;
    int   sidx;
    int   n;
    bit   saw_full;
    bit   prod_done;
    logic [6:0] w55;
    rst_n = 1'b0; tvalid = 1'b0; tdata = 8'h00; parity_mode = 2'b00;
    tvalid_w = 1'b0; tdata_w = 7'h00;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_tready", 32'(tready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_tx_w", 32'(tx_w), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("tready_after_rst", 32'(tready), 32'd1);
    check("tready_after_rst_w", 32'(tready_w), 32'd1);

    // send_one_byte
    push(8'hA5, 2'b00);
    @(negedge clk);
    tvalid = 1'b0;
    check("one_level_after_push", 32'(fifo_level), 32'd1);
    check("one_tx_still_idle", 32'(tx), 32'd1);
    check("one_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("one_tx_start", 32'(tx), 32'd0);
    check("one_level_after_pop", 32'(fifo_level), 32'd0);
    wait_frames(1, 20 * CPB);
    repeat (CPB) @(negedge clk);
    check("one_busy_fall", 32'(busy), 32'd0);
    check("one_tx_idle", 32'(tx), 32'd1);

    // back_to_back
    sidx = frames_started;
    base = frames_done;
    saw_full = 1'b0;
    prod_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 7; i++) push(8'($urandom_range(0, 255)), 2'b00);
        @(negedge clk);
        tvalid = 1'b0;
        prod_done = 1'b1;
      end
      begin
        while (!prod_done) begin
          @(negedge clk);
          if (fifo_level == 3'd4) begin
            saw_full = 1'b1;
            check("full_tready_low", 32'(tready), 32'd0);
          end
        end
      end
    join
    check("b2b_saw_full", 32'(saw_full), 32'd1);
    wait_frames(base + 7, 7 * 12 * CPB);
    for (int k = 1; k < 7; k++)
      check("b2b_no_gap", 32'(start_q[sidx + k] - start_q[sidx + k - 1]), 32'(10 * CPB));

    // parity: mode change mid-frame only affects the next frame
    base = frames_done;
    parity_mode = 2'b01;
    push(8'h03, 2'b01);
    @(negedge clk);
    tvalid = 1'b0;
    wait_started(frames_started + 1);
    parity_mode = 2'b10;
    push(8'h03, 2'b10);
    push(8'($urandom_range(0, 255)), 2'b10);
    @(negedge clk);
    tvalid = 1'b0;
    wait_frames(base + 3, 4 * 12 * CPB);
    parity_mode = 2'b11;
    push(8'h81, 2'b11);
    @(negedge clk);
    tvalid = 1'b0;
    wait_frames(base + 4, 2 * 12 * CPB);
    parity_mode = 2'b00;

    // widths: 7 data bits, 2 stop bits
    w55 = 7'h55;
    @(negedge clk);
    tvalid_w = 1'b1;
    tdata_w = w55;
    check("w_tready", 32'(tready_w), 32'd1);
    @(posedge clk);
    @(negedge clk);
    tvalid_w = 1'b0;
    @(negedge clk);
    check("w_start_edge", 32'(tx_w), 32'd0);
    repeat (CPB / 2) @(negedge clk);
    check("w_start_mid", 32'(tx_w), 32'd0);
    for (int i = 0; i < 7; i++) begin
      repeat (CPB) @(negedge clk);
      check("w_data_bit", 32'(tx_w), 32'(w55[i]));
    end
    repeat (CPB) @(negedge clk);
    check("w_stop1", 32'(tx_w), 32'd1);
    repeat (CPB) @(negedge clk);
    check("w_stop2", 32'(tx_w), 32'd1);
    check("w_busy_in_stop2", 32'(busy_w), 32'd1);
    repeat (CPB) @(negedge clk);
    check("w_busy_after", 32'(busy_w), 32'd0);

    // reset_mid_frame during data bit 3
    base = frames_done;
    n = frames_started;
    for (int i = 0; i < 3; i++) push(8'($urandom_range(0, 255)), 2'b00);
    @(negedge clk);
    tvalid = 1'b0;
    wait_started(n + 1);
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_tready", 32'(tready), 32'd0);
    rst_n = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check("mid_rst_no_stale", 32'(frames_done), 32'(base));
    check("mid_rst_idle", 32'(busy), 32'd0);
    push(8'h3C, 2'b00);
    @(negedge clk);
    tvalid = 1'b0;
    wait_frames(base + 1, 20 * CPB);

    // full_push_pop
    base = frames_done;
    for (int i = 0; i < 5; i++) push(8'($urandom_range(0, 255)), 2'b00);
    @(negedge clk);
    check("fpp_full_level", 32'(fifo_level), 32'd4);
    check("fpp_full_tready", 32'(tready), 32'd0);
    tdata = 8'($urandom_range(0, 255));
    tvalid = 1'b1;
    n = 0;
    while (fifo_level == 3'd4 && n < 15 * CPB) begin
      @(negedge clk);
      n++;
    end
    check("fpp_pop_level", 32'(fifo_level), 32'd3);
    check("fpp_pop_tready", 32'(tready), 32'd1);
    @(posedge clk);
    exp_q.push_back('{data: tdata, mode: 2'b00});
    @(negedge clk);
    tvalid = 1'b0;
    check("fpp_refill_level", 32'(fifo_level), 32'd4);
    check("fpp_refill_tready", 32'(tready), 32'd0);
    wait_frames(base + 6, 7 * 12 * CPB);
    repeat (CPB) @(negedge clk);
    check("end_busy", 32'(busy), 32'd0);
    check("end_level", 32'(fifo_level), 32'd0);
    check("end_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
